// File: rtl/mac_rx_buff_wr.sv
// Receive-side ring-buffer writer: stores 64-bit MAC rx beats and commits each accepted frame behind a header word.
// Define MAC_RX_TIMESTAMP_EN to place a free-running cycle count, latched at SOF, into header[31:0].
module mac_rx_buff_wr #(
  parameter int unsigned BW       = 10,
  parameter int unsigned HEADROOM = 6,
  parameter int unsigned MIN_LEN  = 60,
  parameter int unsigned MAX_LEN  = 1518
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   rx_data,
  input  logic [7:0]    rx_data_valid,
  input  logic          rx_good_frame,
  input  logic          rx_bad_frame,
  output logic          wr_en,
  output logic [BW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          activity,
  output logic [BW-1:0] committed_prod,
  input  logic [BW-1:0] committed_cons,
  output logic [15:0]   dropped_full,
  output logic [15:0]   dropped_bad,
  output logic [15:0]   dropped_len
);

  localparam int unsigned LW        = 16;
  localparam int unsigned CW        = 16;
  localparam logic [BW:0]   OVF_THR  = (BW+1)'((2 ** BW) - HEADROOM);
  localparam logic [BW-1:0] ADDR_ONE = BW'(1);
  localparam logic [LW-1:0] MIN_LEN_W = LW'(MIN_LEN);
  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_COMMIT = 2'd2,
    S_DROP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   aux_q, aux_d;
  logic [LW-1:0]   len_q, len_d;
  logic [BW-1:0]   prod_q, prod_d;
  logic            cause_full_q, cause_full_d;
  logic            wr_en_q, wr_en_d;
  logic [BW-1:0]   wr_addr_q, wr_addr_d;
  logic [63:0]     wr_data_q, wr_data_d;
  logic [CW-1:0]   drop_full_q, drop_full_d;
  logic [CW-1:0]   drop_bad_q, drop_bad_d;
  logic [CW-1:0]   drop_len_q, drop_len_d;

  logic            beat_c;
  logic            eof_c;
  logic [BW-1:0]   occ_c;
  logic            ovf_c;
  logic [LW-1:0]   len_upd_c;
  logic            len_ok_c;
  logic [31:0]     hdr_ts_c;
  logic [63:0]     header_c;
  logic            inc_full_c, inc_bad_c, inc_len_c;

  function automatic logic [3:0] popcnt8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
    return (inc && (c != CNT_MAX)) ? c + CW'(1) : c;
  endfunction

  assign beat_c    = (rx_data_valid != 8'd0);
  assign eof_c     = rx_good_frame | rx_bad_frame;
  assign occ_c     = aux_q - committed_cons;
  assign ovf_c     = ({1'b0, occ_c} > OVF_THR);
  assign len_upd_c = beat_c ? len_q + LW'(popcnt8(rx_data_valid)) : len_q;
  assign len_ok_c  = (len_upd_c >= MIN_LEN_W) && (len_upd_c <= MAX_LEN_W);
  assign header_c  = {1'b0, 15'd0, len_q, hdr_ts_c};

`ifdef MAC_RX_TIMESTAMP_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ts_q, ts_d;
  logic        sof_c;

  // SOF beat is the first valid beat seen while idle or while committing the previous frame
  assign sof_c = beat_c && ((state_q == S_IDLE) || (state_q == S_COMMIT));

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    ts_d  = sof_c ? cyc_q : ts_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 32'd0;
      ts_q  <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      ts_q  <= ts_d;
    end
  end

  assign hdr_ts_c = ts_q;
`else
  assign hdr_ts_c = 32'd0;
`endif

  // Next-state, buffer write and drop accounting
  always_comb begin
    state_d      = state_q;
    aux_d        = aux_q;
    len_d        = len_q;
    prod_d       = prod_q;
    cause_full_d = cause_full_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    inc_full_c   = 1'b0;
    inc_bad_c    = 1'b0;
    inc_len_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        aux_d = prod_q + ADDR_ONE;
        len_d = '0;
        if (beat_c) state_d = S_DATA;
      end

      S_DATA: begin
        if (beat_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = aux_q;
          wr_data_d = rx_data;
          aux_d     = aux_q + ADDR_ONE;
          len_d     = len_upd_c;
        end
        if (ovf_c) begin
          if (eof_c) begin
            inc_full_c = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cause_full_d = 1'b1;
            state_d      = S_DROP;
          end
        end else if ((len_upd_c > MAX_LEN_W) && !eof_c) begin
          cause_full_d = 1'b0;
          state_d      = S_DROP;
        end else if (rx_bad_frame) begin
          inc_bad_c = 1'b1;
          state_d   = S_IDLE;
        end else if (rx_good_frame) begin
          if (len_ok_c) begin
            state_d = S_COMMIT;
          end else begin
            inc_len_c = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      S_COMMIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = prod_q;
        wr_data_d = header_c;
        prod_d    = aux_q;
        len_d     = '0;
        aux_d     = aux_q + ADDR_ONE;
        state_d   = beat_c ? S_DATA : S_IDLE;
      end

      S_DROP: begin
        if (eof_c) begin
          inc_full_c = cause_full_q;
          inc_len_c  = !cause_full_q;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    drop_full_d = sat_inc(drop_full_q, inc_full_c);
    drop_bad_d  = sat_inc(drop_bad_q, inc_bad_c);
    drop_len_d  = sat_inc(drop_len_q, inc_len_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      aux_q        <= '0;
      len_q        <= '0;
      prod_q       <= '0;
      cause_full_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_full_q  <= '0;
      drop_bad_q   <= '0;
      drop_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      aux_q        <= aux_d;
      len_q        <= len_d;
      prod_q       <= prod_d;
      cause_full_q <= cause_full_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      drop_full_q  <= drop_full_d;
      drop_bad_q   <= drop_bad_d;
      drop_len_q   <= drop_len_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign activity       = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign committed_prod = prod_q;
  assign dropped_full   = drop_full_q;
  assign dropped_bad    = drop_bad_q;
  assign dropped_len    = drop_len_q;

endmodule
